// File: rtl/brush_pkg.sv
// Shared types and constants for the brush painter: paint engine states and
// button bit positions.
package brush_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } paint_state_t;

  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;

  localparam int SIZE_GROW   = 0;
  localparam int SIZE_SHRINK = 1;

endpackage

// File: rtl/brush_painter_rect_walker.sv
// Raster walker for one paint job: latches the square bounds and colour,
// advances left-to-right / top-to-bottom on each accepted write.
module brush_painter_rect_walker #(
  parameter int HW = 10,
  parameter int VW = 10,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          step,
  input  logic [HW-1:0] x0,
  input  logic [HW-1:0] x1,
  input  logic [VW-1:0] y0,
  input  logic [VW-1:0] y1,
  input  logic [CW-1:0] color,
  output logic [HW-1:0] wr_x,
  output logic [VW-1:0] wr_y,
  output logic [CW-1:0] wr_data,
  output logic          last
);

  logic [HW-1:0] x0_q;
  logic [HW-1:0] x1_q;
  logic [VW-1:0] y1_q;

  assign last = (wr_x == x1_q) && (wr_y == y1_q);

  // The final pixel is held rather than stepped past, so the write port
  // rests on the last written address once the job completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      wr_x    <= '0;
      wr_y    <= '0;
      wr_data <= '0;
    end else if (start) begin
      x0_q    <= x0;
      x1_q    <= x1;
      y1_q    <= y1;
      wr_x    <= x0;
      wr_y    <= y0;
      wr_data <= color;
    end else if (step && !last) begin
      if (wr_x < x1_q) begin
        wr_x <= wr_x + HW'(1);
      end else begin
        wr_x <= x0_q;
        wr_y <= wr_y + VW'(1);
      end
    end
  end

endmodule

// File: rtl/brush_painter.sv
// Square brush cursor with size/colour control, a framebuffer paint engine
// and a 1-px outline overlay on the video stream.
//  state | meaning
//  IDLE  | no job; cursor may move/resize on tick, paint starts a job
//  WRITE | rasterising the latched square through the req/ack port
module brush_painter
  import brush_pkg::*;
#(
  parameter int RESOLUTION_H = 640,
  parameter int RESOLUTION_V = 480,
  parameter int HPOS_WIDTH   = 10,
  parameter int VPOS_WIDTH   = 10,
  parameter int COLOR_W      = 3,
  parameter int SLOWNESS     = 16,
  parameter int SIZE_MIN     = 1,
  parameter int SIZE_MAX     = 32,
  parameter int SIZE_INIT    = 10,
  parameter int INIT_XPOS    = RESOLUTION_H / 2,
  parameter int INIT_YPOS    = RESOLUTION_V / 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            btn_dir,
  input  logic [1:0]            btn_size,
  input  logic                  btn_paint,
  input  logic [COLOR_W-1:0]    color_sel,
  input  logic                  display_on,
  input  logic [HPOS_WIDTH-1:0] hpos,
  input  logic [VPOS_WIDTH-1:0] vpos,
  input  logic [COLOR_W-1:0]    fb_rgb,
  output logic [COLOR_W-1:0]    rgb,
  output logic                  fb_wr_req,
  output logic [HPOS_WIDTH-1:0] fb_wr_x,
  output logic [VPOS_WIDTH-1:0] fb_wr_y,
  output logic [COLOR_W-1:0]    fb_wr_data,
  input  logic                  fb_wr_ack,
  output logic                  busy
);

  localparam int SIZE_W = $clog2(SIZE_MAX + 1);
  localparam logic [HPOS_WIDTH:0] H_LAST = (HPOS_WIDTH+1)'(RESOLUTION_H - 1);
  localparam logic [VPOS_WIDTH:0] V_LAST = (VPOS_WIDTH+1)'(RESOLUTION_V - 1);

  logic [SLOWNESS-1:0]   tick_cnt;
  logic                  tick;
  logic [HPOS_WIDTH-1:0] x;
  logic [VPOS_WIDTH-1:0] y;
  logic [SIZE_W-1:0]     size;
  paint_state_t          state, next_state;
  logic                  start, step, last;

  assign tick = (tick_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) tick_cnt <= '0;
    else       tick_cnt <= tick_cnt - SLOWNESS'(1);
  end

  // Bound checks run one bit wider than the coordinates so nothing wraps.
  logic [HPOS_WIDTH:0] xe, sxe, he, left_e, right_e;
  logic [VPOS_WIDTH:0] ye, sye, ve, top_e, bot_e;
  logic can_right, can_left, can_down, can_up, grow_ok;

  assign xe      = {1'b0, x};
  assign ye      = {1'b0, y};
  assign sxe     = (HPOS_WIDTH+1)'(size);
  assign sye     = (VPOS_WIDTH+1)'(size);
  assign can_right = (xe + sxe) < H_LAST;
  assign can_left  = xe > sxe;
  assign can_down  = (ye + sye) < V_LAST;
  assign can_up    = ye > sye;
  // Growing by one needs one spare pixel on all four sides.
  assign grow_ok = (size < SIZE_W'(SIZE_MAX)) && can_right && can_left
                   && can_down && can_up;

  always_ff @(posedge clk) begin
    if (reset) begin
      x    <= HPOS_WIDTH'(INIT_XPOS);
      y    <= VPOS_WIDTH'(INIT_YPOS);
      size <= SIZE_W'(SIZE_INIT);
    end else if (tick && !busy) begin
      if (btn_dir[DIR_RIGHT] && !btn_dir[DIR_LEFT] && can_right)
        x <= x + HPOS_WIDTH'(1);
      else if (btn_dir[DIR_LEFT] && !btn_dir[DIR_RIGHT] && can_left)
        x <= x - HPOS_WIDTH'(1);
      if (btn_dir[DIR_DOWN] && !btn_dir[DIR_UP] && can_down)
        y <= y + VPOS_WIDTH'(1);
      else if (btn_dir[DIR_UP] && !btn_dir[DIR_DOWN] && can_up)
        y <= y - VPOS_WIDTH'(1);
      if (btn_size[SIZE_GROW] && !btn_size[SIZE_SHRINK] && grow_ok)
        size <= size + SIZE_W'(1);
      else if (btn_size[SIZE_SHRINK] && !btn_size[SIZE_GROW]
               && size > SIZE_W'(SIZE_MIN))
        size <= size - SIZE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tick && btn_paint)   next_state = WRITE;
      WRITE:   if (fb_wr_ack && last)   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    fb_wr_req = 1'b0;
    if (state == WRITE) begin
      busy      = 1'b1;
      fb_wr_req = 1'b1;
    end
  end

  assign start = (state == IDLE) && tick && btn_paint;
  assign step  = (state == WRITE) && fb_wr_ack;

  brush_painter_rect_walker #(
    .HW (HPOS_WIDTH),
    .VW (VPOS_WIDTH),
    .CW (COLOR_W)
  ) u_walker (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .step    (step),
    .x0      (x - HPOS_WIDTH'(size)),
    .x1      (x + HPOS_WIDTH'(size)),
    .y0      (y - VPOS_WIDTH'(size)),
    .y1      (y + VPOS_WIDTH'(size)),
    .color   (color_sel),
    .wr_x    (fb_wr_x),
    .wr_y    (fb_wr_y),
    .wr_data (fb_wr_data),
    .last    (last)
  );

  logic in_h, in_v, on_border;

  assign he      = {1'b0, hpos};
  assign ve      = {1'b0, vpos};
  assign left_e  = xe - sxe;
  assign right_e = xe + sxe;
  assign top_e   = ye - sye;
  assign bot_e   = ye + sye;
  assign in_h    = (he >= left_e) && (he <= right_e);
  assign in_v    = (ve >= top_e) && (ve <= bot_e);
  assign on_border = ((he == left_e || he == right_e) && in_v)
                  || ((ve == top_e || ve == bot_e) && in_h);

  always_ff @(posedge clk) begin
    if (reset)            rgb <= '0;
    else if (!display_on) rgb <= '0;
    else if (on_border)   rgb <= color_sel;
    else                  rgb <= fb_rgb;
  end

endmodule

// File: tb/tb_brush_painter.sv
// Bench for brush_painter with a fast tick: cursor motion/size limits, paint
// job scoreboard, stall/reset behaviour and the overlay vector table.
module tb_brush_painter;
  import brush_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_dir;
  logic [1:0] btn_size;
  logic       btn_paint;
  logic [2:0] color_sel;
  logic       display_on;
  logic [9:0] hpos, vpos;
  logic [2:0] fb_rgb, rgb;
  logic       fb_wr_req, fb_wr_ack, busy;
  logic [9:0] fb_wr_x, fb_wr_y;
  logic [2:0] fb_wr_data;

  int passed = 0;
  int total  = 0;
  int wr_seen = 0;

  typedef struct {int x; int y; int d;} wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic       disp;
    int         h, v;
    logic [2:0] fb, col, exp_rgb;
  } ovl_vec_t;
  ovl_vec_t ovl[10];

  brush_painter #(.SLOWNESS(2)) dut (
    .clk(clk), .reset(reset), .btn_dir(btn_dir), .btn_size(btn_size),
    .btn_paint(btn_paint), .color_sel(color_sel), .display_on(display_on),
    .hpos(hpos), .vpos(vpos), .fb_rgb(fb_rgb), .rgb(rgb),
    .fb_wr_req(fb_wr_req), .fb_wr_x(fb_wr_x), .fb_wr_y(fb_wr_y),
    .fb_wr_data(fb_wr_data), .fb_wr_ack(fb_wr_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_square(input int cx, input int cy, input int s, input int d);
    for (int yy = cy - s; yy <= cy + s; yy++)
      for (int xx = cx - s; xx <= cx + s; xx++)
        exp_q.push_back('{x: xx, y: yy, d: d});
  endtask

  // Scoreboard: every accepted write is matched against the oldest expected pixel.
  always @(negedge clk) begin
    #1;
    if (!reset && fb_wr_req && fb_wr_ack) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL wr_unexpected: got write (%0d,%0d) expected none", fb_wr_x, fb_wr_y);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_x", int'(fb_wr_x), e.x);
        check("wr_y", int'(fb_wr_y), e.y);
        check("wr_data", int'(fb_wr_data), e.d);
      end
    end
  end

  initial begin
    int busy_cnt;
    reset = 1'b1; btn_dir = '0; btn_size = '0; btn_paint = 1'b0;
    color_sel = '0; display_on = 1'b0; hpos = '0; vpos = '0; fb_rgb = '0;
    fb_wr_ack = 1'b0;

    ovl[0] = '{1'b1, 310, 240, 3'd2, 3'd6, 3'd6};
    ovl[1] = '{1'b1, 320, 240, 3'd2, 3'd6, 3'd2};
    ovl[2] = '{1'b0, 310, 240, 3'd2, 3'd6, 3'd0};
    ovl[3] = '{1'b1, 330, 235, 3'd1, 3'd4, 3'd4};
    ovl[4] = '{1'b1, 315, 230, 3'd1, 3'd4, 3'd4};
    ovl[5] = '{1'b1, 315, 250, 3'd7, 3'd4, 3'd4};
    ovl[6] = '{1'b1, 331, 240, 3'd7, 3'd4, 3'd7};
    ovl[7] = '{1'b1, 310, 229, 3'd3, 3'd5, 3'd3};
    ovl[8] = '{1'b1, 310, 230, 3'd3, 3'd5, 3'd5};
    ovl[9] = '{1'b1, 309, 240, 3'd3, 3'd5, 3'd3};

    clocks(3);
    check("rst_x", int'(dut.x), 320);
    check("rst_y", int'(dut.y), 240);
    check("rst_size", int'(dut.size), 10);
    check("rst_rgb", int'(rgb), 0);
    check("rst_req", int'(fb_wr_req), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;

    // Movement and saturation.
    btn_dir = 4'b0001; clocks(40);
    check("move_right_10", int'(dut.x), 330);
    clocks(1500);
    check("x_sat", int'(dut.x), 629);
    btn_dir = 4'b0011; clocks(40);
    check("both_lr_hold", int'(dut.x), 629);
    btn_dir = 4'b0000; btn_size = 2'b01; clocks(40);
    check("grow_at_edge", int'(dut.size), 10);
    btn_size = 2'b00; btn_dir = 4'b0010; clocks(1236);
    check("back_centre", int'(dut.x), 320);
    btn_dir = 4'b0000; btn_size = 2'b01; clocks(200);
    check("size_max", int'(dut.size), 32);
    btn_size = 2'b10; clocks(200);
    check("size_min", int'(dut.size), 1);
    btn_size = 2'b00;

    // Zero-stall 3x3 job.
    wr_seen = 0; busy_cnt = 0;
    color_sel = 3'd5; fb_wr_ack = 1'b1;
    push_square(320, 240, 1, 5);
    btn_paint = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) btn_paint = 1'b0;
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check("job_writes", wr_seen, 9);
    check("job_busy_cycles", busy_cnt, 9);
    check("job_queue_left", exp_q.size(), 0);
    check("job_idle_after", int'(busy), 0);

    // Stalled job, movement ignored, then reset mid-job.
    fb_wr_ack = 1'b0; color_sel = 3'd3;
    push_square(320, 240, 1, 3);
    btn_paint = 1'b1; clocks(4); btn_paint = 1'b0;
    check("stall_busy", int'(busy), 1);
    color_sel = 3'd6;
    fb_wr_ack = 1'b1; clocks(3);
    fb_wr_ack = 1'b0; btn_dir = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      check("stall_req", int'(fb_wr_req), 1);
      check("stall_x", int'(fb_wr_x), exp_q[0].x);
      check("stall_y", int'(fb_wr_y), exp_q[0].y);
      check("stall_data", int'(fb_wr_data), exp_q[0].d);
      @(negedge clk);
    end
    btn_dir = 4'b0000;
    check("no_move_busy", int'(dut.x), 320);
    fb_wr_ack = 1'b1; clocks(2);
    check("pre_reset_left", exp_q.size(), 4);
    reset = 1'b1; fb_wr_ack = 1'b0;
    @(negedge clk);
    check("abort_req", int'(fb_wr_req), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_state", int'(dut.state), int'(IDLE));
    check("abort_x", int'(dut.x), 320);
    check("abort_size", int'(dut.size), 10);
    exp_q.delete();
    reset = 1'b0;

    // Overlay vectors at size 10 around (320,240).
    for (int i = 0; i < 10; i++) begin
      display_on = ovl[i].disp; hpos = 10'(ovl[i].h); vpos = 10'(ovl[i].v);
      fb_rgb = ovl[i].fb; color_sel = ovl[i].col;
      @(negedge clk);
      check($sformatf("ovl_%0d", i), int'(rgb), int'(ovl[i].exp_rgb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
